// File: rtl/buffer_resultado_ula.sv
// buffer_resultado_ula
// Small first-word-fall-through FIFO that holds ALU results together with the
// opcode and comparator flags that produced them. Unsupported opcodes are
// captured with a zeroed result and an "invalid" marker, so downstream logic
// never sees a stale or meaningless value.
//
// Optional feature: define ULA_BUFFER_CONTADOR_EN to add Contador_Operacoes,
// a saturating 16-bit count of accepted pushes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   Resultado[15:0]   ALU result offered by upstream
//   Sel_Op[3:0]       opcode that produced Resultado
//   Maior/Menor/Igual comparator flags for Resultado
//   Entrada_Valida    upstream offers an entry
//   Entrada_Pronta    buffer has room (not full)
//   Saida_Resultado   head result (0 when empty)
//   Saida_Sel_Op      head opcode (0 when empty)
//   Saida_Flags       head flags {Maior,Menor,Igual} (0 when empty)
//   Saida_Invalida    head opcode was unsupported (0 when empty)
//   Saida_Valida      head entry present
//   Saida_Pronta      downstream consumes head this cycle
//   Ocupacao          number of stored entries
//   Contador_Operacoes (optional) saturating accepted-push count
module buffer_resultado_ula #(
  parameter int PROFUNDIDADE = 4,
  localparam int AW = $clog2(PROFUNDIDADE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Resultado,
  input  logic [3:0]  Sel_Op,
  input  logic        Maior,
  input  logic        Menor,
  input  logic        Igual,
  input  logic        Entrada_Valida,
  output logic        Entrada_Pronta,
  output logic [15:0] Saida_Resultado,
  output logic [3:0]  Saida_Sel_Op,
  output logic [2:0]  Saida_Flags,
  output logic        Saida_Invalida,
  output logic        Saida_Valida,
  input  logic        Saida_Pronta,
  output logic [AW:0] Ocupacao
`ifdef ULA_BUFFER_CONTADOR_EN
  ,
  output logic [15:0] Contador_Operacoes
`endif
);

  logic [15:0] r_mem_res   [PROFUNDIDADE];
  logic [3:0]  r_mem_op    [PROFUNDIDADE];
  logic [2:0]  r_mem_flags [PROFUNDIDADE];
  logic        r_mem_inv   [PROFUNDIDADE];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_ocup;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_op_invalida;

  // Readiness depends only on registered occupancy: a full buffer refuses
  // an entry even when a pop happens in the same cycle.
  assign w_full  = (r_ocup == (AW+1)'(PROFUNDIDADE));
  assign w_empty = (r_ocup == '0);
  assign w_push  = Entrada_Valida && !w_full;
  assign w_pop   = Saida_Pronta && !w_empty;

  // Unsupported opcodes: 0101 and 1100..1111.
  assign w_op_invalida = (Sel_Op == 4'b0101) || (Sel_Op[3:2] == 2'b11);

  // Storage is not reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_res[r_wr_ptr]   <= w_op_invalida ? 16'h0000 : Resultado;
      r_mem_op[r_wr_ptr]    <= Sel_Op;
      r_mem_flags[r_wr_ptr] <= {Maior, Menor, Igual};
      r_mem_inv[r_wr_ptr]   <= w_op_invalida;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ocup   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_ocup <= r_ocup + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

`ifdef ULA_BUFFER_CONTADOR_EN
  logic [15:0] r_contador;

  always_ff @(posedge clk) begin
    if (rst)
      r_contador <= '0;
    else if (w_push && r_contador != 16'hFFFF)
      r_contador <= r_contador + 16'd1;
  end

  assign Contador_Operacoes = r_contador;
`endif

  assign Entrada_Pronta  = !w_full;
  assign Saida_Valida    = !w_empty;
  assign Ocupacao        = r_ocup;
  assign Saida_Resultado = w_empty ? 16'h0000 : r_mem_res[r_rd_ptr];
  assign Saida_Sel_Op    = w_empty ? 4'h0     : r_mem_op[r_rd_ptr];
  assign Saida_Flags     = w_empty ? 3'b000   : r_mem_flags[r_rd_ptr];
  assign Saida_Invalida  = w_empty ? 1'b0     : r_mem_inv[r_rd_ptr];

endmodule

// File: tb/tb_buffer_resultado_ula.sv
module tb_buffer_resultado_ula;

  logic        clk;
  logic        rst;
  logic [15:0] Resultado;
  logic [3:0]  Sel_Op;
  logic        Maior, Menor, Igual;
  logic        Entrada_Valida;
  logic        Entrada_Pronta;
  logic [15:0] Saida_Resultado;
  logic [3:0]  Saida_Sel_Op;
  logic [2:0]  Saida_Flags;
  logic        Saida_Invalida;
  logic        Saida_Valida;
  logic        Saida_Pronta;
  logic [2:0]  Ocupacao;
`ifdef ULA_BUFFER_CONTADOR_EN
  logic [15:0] Contador_Operacoes;
`endif

  int errors = 0;
  int checks = 0;

  buffer_resultado_ula #(.PROFUNDIDADE(4)) dut (
    .clk(clk), .rst(rst),
    .Resultado(Resultado), .Sel_Op(Sel_Op),
    .Maior(Maior), .Menor(Menor), .Igual(Igual),
    .Entrada_Valida(Entrada_Valida), .Entrada_Pronta(Entrada_Pronta),
    .Saida_Resultado(Saida_Resultado), .Saida_Sel_Op(Saida_Sel_Op),
    .Saida_Flags(Saida_Flags), .Saida_Invalida(Saida_Invalida),
    .Saida_Valida(Saida_Valida), .Saida_Pronta(Saida_Pronta),
    .Ocupacao(Ocupacao)
`ifdef ULA_BUFFER_CONTADOR_EN
    , .Contador_Operacoes(Contador_Operacoes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [15:0] res, input logic [3:0] op, input logic [2:0] fl);
    Resultado = res;
    Sel_Op = op;
    {Maior, Menor, Igual} = fl;
    Entrada_Valida = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    Resultado = '0; Sel_Op = '0; Maior = 0; Menor = 0; Igual = 0;
    Entrada_Valida = 0; Saida_Pronta = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ocup",   32'(Ocupacao), 0);
    chk("rst_valida", 32'(Saida_Valida), 0);
    chk("rst_pronta", 32'(Entrada_Pronta), 1);
    chk("rst_res",    32'(Saida_Resultado), 0);
    chk("rst_flags",  32'(Saida_Flags), 0);
`ifdef ULA_BUFFER_CONTADOR_EN
    chk("rst_cnt",    32'(Contador_Operacoes), 0);
`endif

    // Single push, one-cycle latency
    offer(16'h0009, 4'b0000, 3'b100);
    tick();
    Entrada_Valida = 0;
    chk("p1_valida", 32'(Saida_Valida), 1);
    chk("p1_res",    32'(Saida_Resultado), 32'h0009);
    chk("p1_flags",  32'(Saida_Flags), 32'b100);
    chk("p1_ocup",   32'(Ocupacao), 1);
    Saida_Pronta = 1; tick(); Saida_Pronta = 0;
    chk("p1_drain",  32'(Ocupacao), 0);

    // Fill to full, hold off a fifth offer
    for (int i = 1; i <= 4; i++) begin
      offer(16'(i), 4'b0001, 3'b001);
      tick();
    end
    chk("full_ocup",   32'(Ocupacao), 4);
    chk("full_pronta", 32'(Entrada_Pronta), 0);
    offer(16'h0005, 4'b0001, 3'b001);
    tick();
    chk("full_hold_ocup", 32'(Ocupacao), 4);
    chk("full_hold_head", 32'(Saida_Resultado), 1);
    // Full + pop in same cycle: the offer is still refused
    Saida_Pronta = 1;
    tick();
    chk("full_popoffer_ocup", 32'(Ocupacao), 3);
    Entrada_Valida = 0;
    for (int i = 2; i <= 4; i++) begin
      chk("drain_head", 32'(Saida_Resultado), 32'(i));
      tick();
    end
    Saida_Pronta = 0;
    chk("drain_ocup",   32'(Ocupacao), 0);
    chk("drain_valida", 32'(Saida_Valida), 0);
    chk("drain_res0",   32'(Saida_Resultado), 0);

    // Opcode screening
    offer(16'hABCD, 4'b0101, 3'b010); tick();
    offer(16'h1234, 4'b1110, 3'b001); tick();
    offer(16'hBEEF, 4'b0011, 3'b111); tick();
    Entrada_Valida = 0;
    chk("inv0101_res", 32'(Saida_Resultado), 0);
    chk("inv0101_inv", 32'(Saida_Invalida), 1);
    chk("inv0101_op",  32'(Saida_Sel_Op), 32'b0101);
    chk("inv0101_fl",  32'(Saida_Flags), 32'b010);
    Saida_Pronta = 1; tick();
    chk("inv1110_res", 32'(Saida_Resultado), 0);
    chk("inv1110_inv", 32'(Saida_Invalida), 1);
    chk("inv1110_op",  32'(Saida_Sel_Op), 32'b1110);
    tick();
    chk("ok0011_res",  32'(Saida_Resultado), 32'hBEEF);
    chk("ok0011_inv",  32'(Saida_Invalida), 0);
    chk("ok0011_fl",   32'(Saida_Flags), 32'b111);
    tick();
    chk("inv_drain",   32'(Ocupacao), 0);

    // Pop while empty is ignored; push+pop while empty only pushes
    tick();
    chk("empty_pop_ocup", 32'(Ocupacao), 0);
    offer(16'h0077, 4'b0010, 3'b000);
    tick();
    Entrada_Valida = 0;
    chk("empty_pushpop_ocup", 32'(Ocupacao), 1);
    chk("empty_pushpop_res",  32'(Saida_Resultado), 32'h0077);
    tick();
    Saida_Pronta = 0;
    chk("empty_pushpop_drain", 32'(Ocupacao), 0);

    // Steady push+pop at occupancy 2, pointers wrap several times
    offer(16'h0100, 4'b0000, 3'b000); tick();
    offer(16'h0101, 4'b0000, 3'b000); tick();
    for (int i = 0; i < 10; i++) begin
      offer(16'(16'h0102 + i), 4'b0000, 3'b000);
      Saida_Pronta = 1;
      chk("stream_head", 32'(Saida_Resultado), 32'(16'h0100 + i));
      tick();
      chk("stream_ocup", 32'(Ocupacao), 2);
    end
    Saida_Pronta = 0;
    chk("stream_tail_head", 32'(Saida_Resultado), 32'h010A);

    // Reset mid-operation during a push
    offer(16'h0200, 4'b0000, 3'b000); tick();
    chk("pre_rst_ocup", 32'(Ocupacao), 3);
    offer(16'h0300, 4'b0000, 3'b000);
    rst = 1;
    tick();
    rst = 0;
    Entrada_Valida = 0;
    chk("mid_rst_ocup",   32'(Ocupacao), 0);
    chk("mid_rst_valida", 32'(Saida_Valida), 0);
    chk("mid_rst_pronta", 32'(Entrada_Pronta), 1);
    chk("mid_rst_res",    32'(Saida_Resultado), 0);
`ifdef ULA_BUFFER_CONTADOR_EN
    chk("mid_rst_cnt",    32'(Contador_Operacoes), 0);

    // Saturation of the push counter
    offer(16'h0001, 4'b0000, 3'b000);
    Saida_Pronta = 1;
    repeat (70000) tick();
    chk("cnt_sat", 32'(Contador_Operacoes), 32'hFFFF);
    repeat (5) tick();
    chk("cnt_hold", 32'(Contador_Operacoes), 32'hFFFF);
    Entrada_Valida = 0;
    Saida_Pronta = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
